dvs_aer_rx_fifo: RTL and testbench

Parametrised AER receiver for the DVS camera link. It synchronises the asynchronous 4-phase REQ/ACK AER bus and pairs each X/polarity word with the most recent Y word and its timestamp. Completed events are buffered in an internal FIFO and presented downstream on a valid/ready interface. It sits between the camera pins and the event packetiser. It never stalls the camera: when the FIFO is full, events are dropped and counted.

---
 rtl/dvs_aer_rx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_dvs_aer_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_aer_rx_fifo.sv
// dvs_aer_rx_fifo
//
// AER receiver for the DVS camera link. The asynchronous 4-phase REQ/ACK bus
// is synchronised. Each X/polarity word is paired with the most recent
// Y word and the timestamp taken when that Y word arrived. Completed events
// go into a first-word-fall-through FIFO, which the consumer drains through
// a valid/ready interface. The camera is never stalled. If an event cannot
// be stored, it is dropped and counted.
//
// Optional feature macro: DVS_AER_RX_TIMEOUT_EN
//   When this macro is defined, a watchdog counts the cycles spent in ACK_WAIT.
//   If REQ stays high for TIMEOUT_CYCLES cycles, the sticky timeout_err flag
//   is set. When the macro is not defined, timeout_err is tied low.
//
// Ports:
//   clk          single clock
//   rst          synchronous active-high reset
//   aer          AER data bus (asynchronous)
//   xsel         1 = X/polarity word, 0 = Y word (asynchronous)
//   req          AER request (asynchronous, active-high)
//   time_us      free-running microsecond time
//   ack          AER acknowledge
//   ev_valid     FIFO head holds an event
//   ev_ready     consumer accepts the head
//   ev_x/ev_y/ev_ts/ev_pol  head event fields
//   fifo_count   FIFO occupancy
//   drop_count   dropped events, saturating
//   timeout_err  sticky REQ-stuck flag
module dvs_aer_rx_fifo #(
  parameter int AER_BITS       = 10,
  parameter int X_BITS         = 9,
  parameter int Y_BITS         = 8,
  parameter int TS_BITS        = 32,
  parameter int SETUP_CYCLES   = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AER_BITS-1:0]           aer,
  input  logic                          xsel,
  input  logic                          req,
  input  logic [TS_BITS-1:0]            time_us,
  output logic                          ack,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [X_BITS-1:0]             ev_x,
  output logic [Y_BITS-1:0]             ev_y,
  output logic [TS_BITS-1:0]            ev_ts,
  output logic                          ev_pol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int E_W   = X_BITS + Y_BITS + TS_BITS + 1;
  localparam int SC_W  = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETUP_LAST = SC_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETUP    = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_ACK_WAIT = 2'd3;

  // Two-flop synchronisers. Only the *_s_q copies are used by the logic below.
  logic [AER_BITS-1:0] aer_meta_q, aer_s_q;
  logic                xsel_meta_q, xsel_s_q, req_meta_q, req_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aer_meta_q  <= '0;
      aer_s_q     <= '0;
      xsel_meta_q <= 1'b0;
      xsel_s_q    <= 1'b0;
      req_meta_q  <= 1'b0;
      req_s_q     <= 1'b0;
    end else begin
      aer_meta_q  <= aer;
      aer_s_q     <= aer_meta_q;
      xsel_meta_q <= xsel;
      xsel_s_q    <= xsel_meta_q;
      req_meta_q  <= req;
      req_s_q     <= req_meta_q;
    end
  end

  // Handshake FSM
  logic [1:0]      state_q, state_d;
  logic [SC_W-1:0] setup_cnt_q, setup_cnt_d;

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s_q) begin
          setup_cnt_d = '0;
          state_d     = (SETUP_CYCLES == 0) ? ST_CAPTURE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) state_d = ST_CAPTURE;
        else                           setup_cnt_d = setup_cnt_q + 1'b1;
      end
      ST_CAPTURE:  state_d = ST_ACK_WAIT;
      ST_ACK_WAIT: if (!req_s_q) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
    end
  end

  // ack is decoded directly from the state register, so it is glitch-free
  // towards the camera.
  assign ack = (state_q == ST_CAPTURE) || (state_q == ST_ACK_WAIT);

  logic capture;
  assign capture = (state_q == ST_CAPTURE);

  // Most recent Y word and its timestamp. These are shared by every
  // X word that follows.
  logic [Y_BITS-1:0]  y_q;
  logic [TS_BITS-1:0] ts_q;
  logic               y_seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      ts_q     <= '0;
      y_seen_q <= 1'b0;
    end else if (capture && !xsel_s_q) begin
      y_q      <= aer_s_q[Y_BITS-1:0];
      ts_q     <= time_us;
      y_seen_q <= 1'b1;
    end
  end

  // Event FIFO. The read is combinational so that the head entry is
  // visible on ev_* as soon as ev_valid is set (first-word-fall-through).
  logic [E_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [15:0]      drop_q;
  logic             full, pop, push_req, push, drop;
  logic [E_W-1:0]   head;

  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  assign push_req = capture && xsel_s_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && y_seen_q && (!full || pop);
  assign drop     = push_req && !push;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {aer_s_q[X_BITS:1], y_q, ts_q, aer_s_q[0]};
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign ev_pol     = head[0];
  assign ev_ts      = head[TS_BITS:1];
  assign ev_y       = head[TS_BITS+Y_BITS:TS_BITS+1];
  assign ev_x       = head[E_W-1:E_W-X_BITS];
  assign ev_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign drop_count = drop_q;

`ifdef DVS_AER_RX_TIMEOUT_EN
  // Watchdog: counts consecutive ACK_WAIT cycles and saturates at the limit.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == ST_ACK_WAIT) begin
      if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) to_cnt_q <= to_cnt_q + 1'b1;
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_err = timeout_q;
`else
  // The watchdog is not built. TIMEOUT_CYCLES is positive, so this
  // comparison is constant zero.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_dvs_aer_rx_fifo.sv
module tb_dvs_aer_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  aer;
  logic        xsel;
  logic        req;
  logic [31:0] time_us;
  logic        ack, ev_valid, ev_ready, ev_pol, timeout_err;
  logic [8:0]  ev_x;
  logic [7:0]  ev_y;
  logic [31:0] ev_ts;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;

  dvs_aer_rx_fifo dut (
    .clk(clk), .rst(rst), .aer(aer), .xsel(xsel), .req(req), .time_us(time_us),
    .ack(ack), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_x(ev_x), .ev_y(ev_y),
    .ev_ts(ev_ts), .ev_pol(ev_pol), .fifo_count(fifo_count), .drop_count(drop_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [31:0] ts;
    logic        pol;
  } ev_t;

  typedef struct {
    bit          xs;
    logic [9:0]  d;
    logic [31:0] ts;
    int          exp_count;
    int          exp_drop;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ev_t         model_q[$];
  logic [7:0]  y_m;
  logic [31:0] ts_m;
  bit          y_seen_m;
  int          drop_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    y_m = '0; ts_m = '0; y_seen_m = 0; drop_m = 0;
  endtask

  // Every pop is compared against the front of the model queue.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (model_q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        chk("pop_x",   ev_x,   model_q[0].x);
        chk("pop_y",   ev_y,   model_q[0].y);
        chk("pop_ts",  ev_ts,  model_q[0].ts);
        chk("pop_pol", ev_pol, model_q[0].pol);
        $display("pop x=%0h y=%0h ts=%0d pol=%0d", ev_x, ev_y, ev_ts, ev_pol);
        void'(model_q.pop_front());
      end
    end
  end

  // Performs one full 4-phase transfer and checks ack timing.
  // When pop_flag is set, ev_ready is pulsed so that it coincides with the capture edge.
  task automatic handshake(input bit xs, input logic [9:0] d, input logic [31:0] ts,
                           input bit pop_flag, input int hold);
    int idx;
    @(negedge clk);
    aer = d; xsel = xs; time_us = ts; req = 1'b1;
    idx = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ack) begin idx = k; break; end
    end
    chk("ack_rise_edge", idx, 5);
    if (xs) begin
      if (!y_seen_m || (model_q.size() >= 8 && !pop_flag)) drop_m++;
      else model_q.push_back('{d[9:1], y_m, ts_m, d[0]});
    end else begin
      y_m = d[7:0]; ts_m = ts; y_seen_m = 1;
    end
    if (pop_flag) begin
      ev_ready = 1'b1;
      @(posedge clk); #1;
      ev_ready = 1'b0;
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    idx = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (!ack) begin idx = k; break; end
    end
    chk("ack_fall_edge", idx, 2);
    repeat (2) @(posedge clk); #1;
    $display("handshake xsel=%0d aer=%0h ts=%0d -> count=%0d drop=%0d",
             xs, d, ts, fifo_count, drop_count);
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    ev_ready = 1'b1;
    n = 0;
    while (fifo_count != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain_empty", fifo_count, 0);
    chk("model_empty", model_q.size(), 0);
    ev_ready = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 10'h012, 32'd100, 0, 0};
    vecs[1]  = '{1, 10'h0A5, 32'd999, 1, 0};
    vecs[2]  = '{1, 10'h1FE, 32'd7,   2, 0};
    vecs[3]  = '{1, 10'h003, 32'd7,   3, 0};
    vecs[4]  = '{1, 10'h104, 32'd7,   4, 0};
    vecs[5]  = '{1, 10'h205, 32'd7,   5, 0};
    vecs[6]  = '{1, 10'h306, 32'd7,   6, 0};
    vecs[7]  = '{1, 10'h007, 32'd7,   7, 0};
    vecs[8]  = '{1, 10'h3FF, 32'd7,   8, 0};
    vecs[9]  = '{1, 10'h2AA, 32'd7,   8, 1};
    vecs[10] = '{1, 10'h155, 32'd7,   8, 2};

    rst = 1'b1; aer = '0; xsel = 1'b0; req = 1'b0; time_us = '0; ev_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", ack, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_timeout", timeout_err, 0);
    @(negedge clk); rst = 1'b0;

    // Fill past full with the consumer stalled. Capacity is reached, then drops begin.
    for (int i = 0; i < 11; i++) begin
      handshake(vecs[i].xs, vecs[i].d, vecs[i].ts, 0, 0);
      chk("vec_count", fifo_count, vecs[i].exp_count);
      chk("vec_drop", drop_count, vecs[i].exp_drop);
      if (vecs[i].exp_count > 0) begin
        chk("vec_head_x", ev_x, 9'h052);
        chk("vec_head_y", ev_y, 8'h12);
        chk("vec_head_ts", ev_ts, 32'd100);
        chk("vec_head_pol", ev_pol, 1);
      end
    end

    // Full FIFO, with a pop landing on the same edge as an X capture.
    handshake(1, 10'h0F0, 32'd5, 1, 0);
    chk("full_pushpop_count", fifo_count, 8);
    chk("full_pushpop_drop", drop_count, 2);
    chk("full_pushpop_head", ev_x, 9'h0FF);
    drain();

    // One Y word followed by three X words, with the consumer always ready.
    @(posedge clk); #1; ev_ready = 1'b1;
    handshake(0, 10'h034, 32'd500, 0, 0);
    handshake(1, 10'h011, 32'd501, 0, 0);
    handshake(1, 10'h222, 32'd502, 0, 0);
    handshake(1, 10'h3C1, 32'd503, 0, 0);
    chk("streamed_count", fifo_count, 0);
    chk("streamed_model", model_q.size(), 0);
    chk("streamed_drop", drop_count, 2);
    ev_ready = 1'b0;

    // Reset asserted in the middle of a handshake.
    @(negedge clk); aer = 10'h055; xsel = 1'b0; req = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("mid_ack_high", ack, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ack", ack, 0);
    model_reset();
    @(negedge clk); rst = 1'b0; req = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("mid_rst_ack_stays_low", ack, 0);
    chk("mid_rst_drop", drop_count, 0);

    // An X word arrives before any Y word: it is dropped, but the handshake still completes.
    handshake(1, 10'h0A5, 32'd1, 0, 0);
    chk("noy_count", fifo_count, 0);
    chk("noy_drop", drop_count, 1);

    // REQ held high: the watchdog trips only when the macro is defined.
    handshake(0, 10'h009, 32'd42, 0, 0);
    @(posedge clk); #1; ev_ready = 1'b1;
    handshake(1, 10'h013, 32'd43, 0, 1100);
`ifdef DVS_AER_RX_TIMEOUT_EN
    chk("timeout_err", timeout_err, 1);
`else
    chk("timeout_err", timeout_err, 0);
`endif
    chk("timeout_model", model_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
